pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline stall and flush sequencer for the five-stage term-project CPU. It combines three things: load-use hazard detection between EX and DE, multi-cycle multiply/divide occupancy of EX, and taken-branch squash. From these it drives the PC, fetch-buffer, DE/EX and EX/MEM pipeline-register controls. It replaces the standalone combinational hazard detector at the IF/DE/EX boundary and adds a saturating stall-cycle counter for performance measurement.

## Interface
- MUL_CYCLES, 4: total EX-stage residency of a multiply, legal range 2..2^CNT_W
- DIV_CYCLES, 16: total EX-stage residency of a divide, legal range 2..2^CNT_W
- CNT_W, 5: width of the occupancy down-counter
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- EXreadbit  in  1  active-low; 0 = load instruction in EX
- EXwriteAddr  in  4  destination register of the EX instruction
- DEop1Addr  in  4  source operand 1 of the DE instruction
- DEop2Addr  in  4  source operand 2 of the DE instruction
- EXmulop  in  1  EX instruction is a multiply
- EXdivop  in  1  EX instruction is a divide
- EXbranchtaken  in  1  branch in EX resolved taken
- pcenable  out  1  PC register load enable
- fetchbuffenable  out  1  IF/DE fetch-buffer load enable
- fetchflush  out  1  clear IF/DE fetch buffer to NOP
- zerocontrol  out  1  load zero control word into DE/EX (bubble into EX)
- deexenable  out  1  DE/EX register load enable (0 = hold EX instruction)
- exmembubble  out  1  load zero control word into EX/MEM
- busy  out  1  multi-cycle op occupying EX
- stallcnt  out  16  saturating count of cycles with pcenable=0 (excluding reset)

## Operation
- States: RUN, MULBUSY, MULLAST. Counter `cnt` is CNT_W bits.
- Outputs are decoded combinationally from the state and the current inputs. State, `cnt` and `stallcnt` are registered.
- Normal (RUN, no event): pcenable=1, fetchbuffenable=1, deexenable=1, fetchflush=0, zerocontrol=0, exmembubble=0, busy=0.
- Priority inside RUN: branch > mul/div > load-use.
- Branch (EXbranchtaken=1):
  - Outputs: fetchflush=1, zerocontrol=1, pcenable=1, fetchbuffenable=1.
  - Stays in RUN.
  - Mul/div and load-use are ignored that cycle.
- Mul/div start (EXmulop|EXdivop):
  - Outputs: pcenable=0, fetchbuffenable=0, deexenable=0, exmembubble=1, busy=1.
  - `cnt` loads MUL_CYCLES-2 (or DIV_CYCLES-2; EXmulop wins if both are set).
  - Next state is MULLAST if the loaded value is 0, otherwise MULBUSY.
- MULBUSY:
  - Outputs identical to mul/div start; all inputs are ignored.
  - `cnt` decrements each cycle; on reaching 1→0 the next state is MULLAST.
- MULLAST:
  - Normal outputs; the mul/div result advances to MEM.
  - EXmulop/EXdivop are ignored, so the op is not re-triggered.
  - Branch and load-use are still evaluated.
  - Next state is RUN.
- Load-use (EXreadbit=0 and EXwriteAddr equals DEop1Addr or DEop2Addr):
  - Outputs: pcenable=0, fetchbuffenable=0, zerocontrol=1.
  - Exactly one bubble; no state change.
- stallcnt: increments when pcenable=0 and rst=0, saturates at 16'hFFFF.

## Timing
- Reset values (outputs forced while rst=1; state and counters take these values at the edge):
  - state=RUN, cnt=0, stallcnt=0, busy=0.
  - pcenable=0, fetchbuffenable=0, fetchflush=1, zerocontrol=1, deexenable=1, exmembubble=1.
- Load-use and branch responses appear in the same cycle as the inputs (zero latency).
- A multiply holds EX for exactly MUL_CYCLES cycles: MUL_CYCLES-1 stall cycles, then one MULLAST cycle.
- With MUL_CYCLES=2, the sequence is start cycle → MULLAST; MULBUSY is never entered.
- rst asserted in MULBUSY/MULLAST: state is RUN after the edge and cnt=0. The held instruction is discarded by the reset bubbles.
- Branch and load-use in the same cycle: branch response only.

## Configuration
- MULDIV_STALL_EN defined: multi-cycle sequencing as above.
- MULDIV_STALL_EN undefined:
  - EXmulop/EXdivop are ignored and busy is tied to 0.
  - The FSM reduces to permanent RUN (MULBUSY/MULLAST and `cnt` are not built).
  - Load-use, branch and stallcnt behave unchanged.

## Test plan
- Load-use: after reset, EXreadbit=0, EXwriteAddr=5, DEop1Addr=2, DEop2Addr=5 → same cycle pcenable=0, fetchbuffenable=0, zerocontrol=1; stallcnt=1 next cycle.
- No hazard: EXreadbit=1, EXwriteAddr=5, DEop1Addr=5, DEop2Addr=5 → normal outputs; EXreadbit=0 with addrs 2/3 → normal outputs.
- Multiply, MUL_CYCLES=4: EXmulop=1 held for 5 cycles → pcenable=0 and busy=1 for 3 cycles, 4th cycle normal (MULLAST), 5th cycle new stall (new op); stallcnt=3 after the first op.
- Divide, DIV_CYCLES=16, with EXbranchtaken pulsed mid-op → 15 stall cycles, branch ignored while in MULBUSY; branch taken in RUN → fetchflush=1, zerocontrol=1, pcenable=1.
- Reset mid-op: rst=1 at 2nd MULBUSY cycle → next cycle state RUN, stallcnt=0, busy=0; rst cycle outputs fetchflush=1, exmembubble=1.
- Priority: EXbranchtaken=1 with EXreadbit=0 and an address match, then EXbranchtaken=1 with EXmulop=1 → branch response only, state stays RUN, stallcnt unchanged.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and pipe_stall_ctrl.
// The datapath (master) drives the EX/DE hazard inputs; the sequencer (slave)
// returns the pipeline-register and PC control strobes plus the stall counter.
interface pipe_stall_ctrl_if;
    logic        EXreadbit;
    logic [3:0]  EXwriteAddr;
    logic [3:0]  DEop1Addr;
    logic [3:0]  DEop2Addr;
    logic        EXmulop;
    logic        EXdivop;
    logic        EXbranchtaken;

    logic        pcenable;
    logic        fetchbuffenable;
    logic        fetchflush;
    logic        zerocontrol;
    logic        deexenable;
    logic        exmembubble;
    logic        busy;
    logic [15:0] stallcnt;

    modport master (
        output EXreadbit, EXwriteAddr, DEop1Addr, DEop2Addr,
               EXmulop, EXdivop, EXbranchtaken,
        input  pcenable, fetchbuffenable, fetchflush, zerocontrol,
               deexenable, exmembubble, busy, stallcnt
    );

    modport slave (
        input  EXreadbit, EXwriteAddr, DEop1Addr, DEop2Addr,
               EXmulop, EXdivop, EXbranchtaken,
        output pcenable, fetchbuffenable, fetchflush, zerocontrol,
               deexenable, exmembubble, busy, stallcnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use hazard, multi-cycle mul/div
// occupancy of EX and taken-branch squash, plus a saturating stall counter.
// Define MULDIV_STALL_EN to build the mul/div occupancy FSM; without it the
// sequencer is permanently in RUN and EXmulop/EXdivop are ignored.
module pipe_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    logic        w_loaduse;
    logic        w_start;     // mul/div begins this cycle (RUN only)
    logic        w_hold;      // mul/div still occupying EX
    logic        w_pcenable;
    logic        w_fetchbuffenable;
    logic        w_fetchflush;
    logic        w_zerocontrol;
    logic        w_deexenable;
    logic        w_exmembubble;
    logic        w_busy;
    logic [15:0] r_stallcnt;

    assign w_loaduse = !bus.EXreadbit &&
                       ((bus.EXwriteAddr == bus.DEop1Addr) ||
                        (bus.EXwriteAddr == bus.DEop2Addr));

`ifdef MULDIV_STALL_EN
    typedef enum logic [1:0] {RUN, MULBUSY, MULLAST} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load;

    assign w_load  = bus.EXmulop ? CNT_W'(MUL_CYCLES - 2) : CNT_W'(DIV_CYCLES - 2);
    assign w_start = (r_state == RUN) && (bus.EXmulop || bus.EXdivop);
    assign w_hold  = (r_state == MULBUSY);

    // Occupancy FSM: a taken branch in RUN suppresses the mul/div start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_start && !bus.EXbranchtaken) begin
                        r_cnt   <= w_load;
                        r_state <= (w_load == '0) ? MULLAST : MULBUSY;
                    end
                end
                MULBUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= MULLAST;
                    end
                end
                MULLAST: r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end
`else
    logic w_unused_muldiv;

    assign w_start = 1'b0;
    assign w_hold  = 1'b0;
    assign w_unused_muldiv = bus.EXmulop ^ bus.EXdivop ^
                             (MUL_CYCLES != DIV_CYCLES) ^ (CNT_W > 0);
`endif

    // Control decode: reset > mul/div hold > branch > mul/div start > load-use.
    always_comb begin
        w_pcenable        = 1'b1;
        w_fetchbuffenable = 1'b1;
        w_fetchflush      = 1'b0;
        w_zerocontrol     = 1'b0;
        w_deexenable      = 1'b1;
        w_exmembubble     = 1'b0;
        w_busy            = 1'b0;
        if (rst) begin
            w_pcenable        = 1'b0;
            w_fetchbuffenable = 1'b0;
            w_fetchflush      = 1'b1;
            w_zerocontrol     = 1'b1;
            w_exmembubble     = 1'b1;
        end else if (w_hold || (w_start && !bus.EXbranchtaken)) begin
            w_pcenable        = 1'b0;
            w_fetchbuffenable = 1'b0;
            w_deexenable      = 1'b0;
            w_exmembubble     = 1'b1;
            w_busy            = 1'b1;
        end else if (bus.EXbranchtaken) begin
            w_fetchflush      = 1'b1;
            w_zerocontrol     = 1'b1;
        end else if (w_loaduse) begin
            w_pcenable        = 1'b0;
            w_fetchbuffenable = 1'b0;
            w_zerocontrol     = 1'b1;
        end
    end

    // Saturating count of non-reset cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallcnt <= '0;
        end else if (!w_pcenable && (r_stallcnt != '1)) begin
            r_stallcnt <= r_stallcnt + 1'b1;
        end
    end

    assign bus.pcenable        = w_pcenable;
    assign bus.fetchbuffenable = w_fetchbuffenable;
    assign bus.fetchflush      = w_fetchflush;
    assign bus.zerocontrol     = w_zerocontrol;
    assign bus.deexenable      = w_deexenable;
    assign bus.exmembubble     = w_exmembubble;
    assign bus.busy            = w_busy;
    assign bus.stallcnt        = r_stallcnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: two instances (MUL=4/DIV=16 and the
// MUL=2/DIV=3 boundary) share stimulus; expected controls come from a
// cycle-counting reference model and are checked by a separate monitor.
module tb_pipe_stall_ctrl;

`ifdef MULDIV_STALL_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    // Control vector order: {pc, fb, flush, zero, deex, exmemb, busy}
    localparam logic [6:0] O_RESET = 7'b0011110;
    localparam logic [6:0] O_NORM  = 7'b1100100;
    localparam logic [6:0] O_MD    = 7'b0000011;
    localparam logic [6:0] O_BR    = 7'b1111100;
    localparam logic [6:0] O_LU    = 7'b0001100;

    typedef struct {
        logic [1:0][6:0]  ctrl;
        logic [1:0][15:0] scnt;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus_a ();
    pipe_stall_ctrl_if bus_b ();

    pipe_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(16), .CNT_W(5)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    pipe_stall_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model state: remaining pure-stall cycles, pending last cycle, stall count.
    int   mulc [2] = '{4, 2};
    int   divc [2] = '{16, 3};
    int   left [2] = '{0, 0};
    bit   last [2] = '{0, 0};
    int   scnt [2] = '{0, 0};

    task automatic model_step(input bit r, input bit br, input bit mul,
                              input bit div, input bit lu);
        exp_t e;
        logic [6:0] o;
        bit inlast;
        for (int k = 0; k < 2; k++) begin
            e.scnt[k] = 16'(scnt[k]);
            if (r) begin
                o = O_RESET;
                left[k] = 0;
                last[k] = 1'b0;
            end else if (EN && left[k] > 0) begin
                o = O_MD;
                left[k]--;
                if (left[k] == 0) last[k] = 1'b1;
            end else begin
                inlast  = last[k];
                last[k] = 1'b0;
                if (br) begin
                    o = O_BR;
                end else if (EN && !inlast && (mul || div)) begin
                    o = O_MD;
                    left[k] = (mul ? mulc[k] : divc[k]) - 2;
                    if (left[k] == 0) last[k] = 1'b1;
                end else if (lu) begin
                    o = O_LU;
                end else begin
                    o = O_NORM;
                end
            end
            e.ctrl[k] = o;
            if (r) scnt[k] = 0;
            else if (!o[6] && scnt[k] < 65535) scnt[k]++;
        end
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit rb, input logic [3:0] wa,
                         input logic [3:0] a1, input logic [3:0] a2,
                         input bit mul, input bit div, input bit br);
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        bus_a.EXreadbit = rb;  bus_b.EXreadbit = rb;
        bus_a.EXwriteAddr = wa; bus_b.EXwriteAddr = wa;
        bus_a.DEop1Addr = a1;  bus_b.DEop1Addr = a1;
        bus_a.DEop2Addr = a2;  bus_b.DEop2Addr = a2;
        bus_a.EXmulop = mul;   bus_b.EXmulop = mul;
        bus_a.EXdivop = div;   bus_b.EXdivop = div;
        bus_a.EXbranchtaken = br; bus_b.EXbranchtaken = br;
        model_step(r, br, mul, div, !rb && (wa == a1 || wa == a2));
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0][6:0]  got_c;
        logic [1:0][15:0] got_s;
        if (q.size() > 0) begin
            e = q.pop_front();
            got_c[0] = {bus_a.pcenable, bus_a.fetchbuffenable, bus_a.fetchflush,
                        bus_a.zerocontrol, bus_a.deexenable, bus_a.exmembubble, bus_a.busy};
            got_c[1] = {bus_b.pcenable, bus_b.fetchbuffenable, bus_b.fetchflush,
                        bus_b.zerocontrol, bus_b.deexenable, bus_b.exmembubble, bus_b.busy};
            got_s[0] = bus_a.stallcnt;
            got_s[1] = bus_b.stallcnt;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (got_c[k] !== e.ctrl[k]) begin
                    n_fail++;
                    $display("FAIL ctrl dut%0d cycle %0d: got %b want %b", k, e.cyc, got_c[k], e.ctrl[k]);
                end
                n_tests++;
                if (got_s[k] !== e.scnt[k]) begin
                    n_fail++;
                    $display("FAIL stallcnt dut%0d cycle %0d: got %0d want %0d", k, e.cyc, got_s[k], e.scnt[k]);
                end
            end
        end
    end

    initial begin
        bus_a.EXreadbit = 1'b1; bus_b.EXreadbit = 1'b1;
        bus_a.EXwriteAddr = '0; bus_b.EXwriteAddr = '0;
        bus_a.DEop1Addr = '0;   bus_b.DEop1Addr = '0;
        bus_a.DEop2Addr = '0;   bus_b.DEop2Addr = '0;
        bus_a.EXmulop = 1'b0;   bus_b.EXmulop = 1'b0;
        bus_a.EXdivop = 1'b0;   bus_b.EXdivop = 1'b0;
        bus_a.EXbranchtaken = 1'b0; bus_b.EXbranchtaken = 1'b0;

        // Reset
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        // Load-use, then the two no-hazard patterns
        drive(0, 0, 5, 2, 5, 0, 0, 0);
        drive(0, 1, 5, 5, 5, 0, 0, 0);
        drive(0, 0, 5, 2, 3, 0, 0, 0);
        // Multiply held for five cycles
        repeat (5) drive(0, 1, 0, 1, 2, 1, 0, 0);
        repeat (6) drive(0, 1, 0, 1, 2, 0, 0, 0);
        // Divide with a branch pulse mid-op, then a branch in RUN
        drive(0, 1, 0, 1, 2, 0, 1, 0);
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 1, 2, 0, 0, i == 4);
        drive(0, 1, 0, 1, 2, 0, 0, 1);
        // Reset during the second MULBUSY cycle
        drive(0, 1, 0, 1, 2, 1, 0, 0);
        drive(0, 1, 0, 1, 2, 0, 0, 0);
        drive(1, 1, 0, 1, 2, 0, 0, 0);
        drive(0, 1, 0, 1, 2, 0, 0, 0);
        // Priority: branch over load-use, branch over multiply
        drive(0, 0, 7, 7, 1, 0, 0, 1);
        drive(0, 1, 0, 1, 2, 1, 0, 1);
        drive(0, 1, 0, 1, 2, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(63) == 0, 1'($urandom_range(1)),
                  4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3)),
                  $urandom_range(15) == 0, $urandom_range(15) == 0,
                  $urandom_range(5) == 0);
        end
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
